sprite_line_fetcher: RTL and testbench

- Producer side of the sprite line interface. Once per scanline it scans sprite attribute memory and finds every sprite that covers the current line.
- For each hit it computes the sprite line address, tile row and flip, and fetches the 32-bit line mask.
- It emits one descriptor per hit, in ascending sprite index order, over a valid/ready handshake to the sprite line renderer.
- It sits between the attribute/mask memories and the renderer.

---
 rtl/sprite_line_fetcher.sv | 196 +++++++++++++++++++
 tb/tb_sprite_line_fetcher.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_fetcher.sv
// Sprite line fetcher: scans sprite attribute memory once per scanline, finds
// the sprites that cover the line, fetches each one's line mask and hands one
// descriptor per hit to the renderer over a valid/ready handshake.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for i_line_start
// RD_ATTR | attribute read strobe out for the current index
// CHECK   | attribute data present, decide hit/miss/overflow
// RD_MASK | mask read strobe out for the computed line address
// CAP     | mask data present, load descriptor and raise o_valid
// EMIT    | descriptor held until the renderer takes it
// DONE    | o_line_done pulse, back to IDLE next cycle
module sprite_line_fetcher #(
    parameter int NUM_SPRITES   = 64,
    parameter int MAX_PER_LINE  = 16,
    parameter int SPRITE_HEIGHT = 32
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic                           i_line_start,
    input  logic [9:0]                     i_line_y,
    output logic                           o_attr_rd,
    output logic [$clog2(NUM_SPRITES)-1:0] o_attr_addr,
    input  logic                           i_attr_en,
    input  logic [9:0]                     i_attr_y,
    input  logic [9:0]                     i_attr_x,
    input  logic [15:0]                    i_attr_base,
    input  logic                           i_attr_vflip,
    input  logic                           i_attr_hflip,
    output logic                           o_mask_rd,
    output logic [15:0]                    o_mask_addr,
    input  logic [31:0]                    i_mask_data,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [31:0]                    o_sprite_line_mask,
    output logic [15:0]                    o_sprite_line_address,
    output logic [9:0]                     o_sprite_start_x,
    output logic                           o_tile_row,
    output logic                           o_row_flip,
    output logic                           o_busy,
    output logic                           o_line_done,
    output logic                           o_overflow
);

    localparam int IW = $clog2(NUM_SPRITES);
    localparam int CW = $clog2(MAX_PER_LINE + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SPRITES - 1);
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_PER_LINE);
    localparam logic [9:0]    HEIGHT   = 10'(SPRITE_HEIGHT);
    localparam logic [9:0]    HEIGHT_M1 = 10'(SPRITE_HEIGHT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ATTR = 3'd1,
        CHECK   = 3'd2,
        RD_MASK = 3'd3,
        CAP     = 3'd4,
        EMIT    = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t          r_state;
    logic [9:0]      r_line_y;
    logic [IW-1:0]   r_index;
    logic [CW-1:0]   r_count;
    logic [9:0]      r_lat_x;
    logic            r_lat_tile_row;
    logic            r_lat_hflip;

    logic [9:0]      w_row;
    logic            w_hit;
    logic [9:0]      w_frow;
    logic [15:0]     w_addr;
    logic            w_tile_row;

    // Row within the sprite; the 10-bit wrap lets sprites straddle line 0.
    always_comb begin
        w_row      = r_line_y - i_attr_y;
        w_hit      = i_attr_en && (w_row < HEIGHT);
        w_frow     = i_attr_vflip ? (HEIGHT_M1 - w_row) : w_row;
        w_addr     = i_attr_base + {6'd0, w_frow};
        w_tile_row = (SPRITE_HEIGHT == 32) ? w_frow[4] : 1'b0;
    end

    // Scan sequencer; every output is loaded here so all of them are registered.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state               <= IDLE;
            r_line_y              <= '0;
            r_index               <= '0;
            r_count               <= '0;
            r_lat_x               <= '0;
            r_lat_tile_row        <= 1'b0;
            r_lat_hflip           <= 1'b0;
            o_attr_rd             <= 1'b0;
            o_attr_addr           <= '0;
            o_mask_rd             <= 1'b0;
            o_mask_addr           <= '0;
            o_valid               <= 1'b0;
            o_sprite_line_mask    <= '0;
            o_sprite_line_address <= '0;
            o_sprite_start_x      <= '0;
            o_tile_row            <= 1'b0;
            o_row_flip            <= 1'b0;
            o_busy                <= 1'b0;
            o_line_done           <= 1'b0;
            o_overflow            <= 1'b0;
        end else if (i_line_start) begin
            // A start in any state (re)starts the scan; a pending descriptor is dropped.
            r_state     <= RD_ATTR;
            r_line_y    <= i_line_y;
            r_index     <= '0;
            r_count     <= '0;
            o_attr_rd   <= 1'b1;
            o_attr_addr <= '0;
            o_mask_rd   <= 1'b0;
            o_valid     <= 1'b0;
            o_busy      <= 1'b1;
            o_line_done <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    o_busy <= 1'b0;
                end
                RD_ATTR: begin
                    o_attr_rd <= 1'b0;
                    r_state   <= CHECK;
                end
                CHECK: begin
                    if (w_hit) begin
                        if (r_count < MAX_CNT) begin
                            r_lat_x        <= i_attr_x;
                            r_lat_tile_row <= w_tile_row;
                            r_lat_hflip    <= i_attr_hflip;
                            o_mask_rd      <= 1'b1;
                            o_mask_addr    <= w_addr;
                            r_state        <= RD_MASK;
                        end else begin
                            o_overflow  <= 1'b1;
                            o_line_done <= 1'b1;
                            r_state     <= DONE;
                        end
                    end else if (r_index != LAST_IDX) begin
                        r_index     <= r_index + IW'(1);
                        o_attr_rd   <= 1'b1;
                        o_attr_addr <= r_index + IW'(1);
                        r_state     <= RD_ATTR;
                    end else begin
                        o_line_done <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                RD_MASK: begin
                    o_mask_rd <= 1'b0;
                    r_state   <= CAP;
                end
                CAP: begin
                    o_sprite_line_mask    <= i_mask_data;
                    o_sprite_line_address <= o_mask_addr;
                    o_sprite_start_x      <= r_lat_x;
                    o_tile_row            <= r_lat_tile_row;
                    o_row_flip            <= r_lat_hflip;
                    o_valid               <= 1'b1;
                    r_state               <= EMIT;
                end
                EMIT: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        r_count <= r_count + CW'(1);
                        if (r_index == LAST_IDX) begin
                            o_line_done <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_index     <= r_index + IW'(1);
                            o_attr_rd   <= 1'b1;
                            o_attr_addr <= r_index + IW'(1);
                            r_state     <= RD_ATTR;
                        end
                    end
                end
                DONE: begin
                    o_line_done <= 1'b0;
                    o_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    o_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Directed testbench for sprite_line_fetcher with behavioural attribute and
// mask memories (one-cycle read latency) and a descriptor monitor.
module tb_sprite_line_fetcher;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_line_start = 1'b0;
    logic [9:0]  i_line_y = '0;
    logic        o_attr_rd;
    logic [5:0]  o_attr_addr;
    logic        attr_en = 1'b0;
    logic [9:0]  attr_y = '0;
    logic [9:0]  attr_x = '0;
    logic [15:0] attr_base = '0;
    logic        attr_vflip = 1'b0;
    logic        attr_hflip = 1'b0;
    logic        o_mask_rd;
    logic [15:0] o_mask_addr;
    logic [31:0] mask_data = '0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [31:0] o_mask;
    logic [15:0] o_addr;
    logic [9:0]  o_x;
    logic        o_tile_row;
    logic        o_row_flip;
    logic        o_busy;
    logic        o_line_done;
    logic        o_overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic        a_en   [64];
    logic [9:0]  a_y    [64];
    logic [9:0]  a_x    [64];
    logic [15:0] a_base [64];
    logic        a_vf   [64];
    logic        a_hf   [64];

    int          nd = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    bit          valid_seen = 0;
    logic [31:0] d_mask [32];
    logic [15:0] d_addr [32];
    logic [9:0]  d_x    [32];
    logic        d_tr   [32];
    logic        d_rf   [32];

    sprite_line_fetcher dut (
        .i_clk                 (clk),
        .i_reset_n             (rst_n),
        .i_line_start          (i_line_start),
        .i_line_y              (i_line_y),
        .o_attr_rd             (o_attr_rd),
        .o_attr_addr           (o_attr_addr),
        .i_attr_en             (attr_en),
        .i_attr_y              (attr_y),
        .i_attr_x              (attr_x),
        .i_attr_base           (attr_base),
        .i_attr_vflip          (attr_vflip),
        .i_attr_hflip          (attr_hflip),
        .o_mask_rd             (o_mask_rd),
        .o_mask_addr           (o_mask_addr),
        .i_mask_data           (mask_data),
        .o_valid               (o_valid),
        .i_ready               (i_ready),
        .o_sprite_line_mask    (o_mask),
        .o_sprite_line_address (o_addr),
        .o_sprite_start_x      (o_x),
        .o_tile_row            (o_tile_row),
        .o_row_flip            (o_row_flip),
        .o_busy                (o_busy),
        .o_line_done           (o_line_done),
        .o_overflow            (o_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mask_of(input logic [15:0] a);
        if (a == 16'h100A) return 32'hF0F0F0F0;
        return {a, ~a};
    endfunction

    // Attribute and mask memories: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (o_attr_rd) begin
            attr_en    <= a_en[o_attr_addr];
            attr_y     <= a_y[o_attr_addr];
            attr_x     <= a_x[o_attr_addr];
            attr_base  <= a_base[o_attr_addr];
            attr_vflip <= a_vf[o_attr_addr];
            attr_hflip <= a_hf[o_attr_addr];
        end
        if (o_mask_rd) mask_data <= mask_of(o_mask_addr);
    end

    // Descriptor / line-done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (o_valid) valid_seen = 1;
        if (o_valid && i_ready) begin
            if (nd < 32) begin
                d_mask[nd] = o_mask;
                d_addr[nd] = o_addr;
                d_x[nd]    = o_x;
                d_tr[nd]   = o_tile_row;
                d_rf[nd]   = o_row_flip;
            end
            nd++;
        end
        if (o_line_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clear_attrs();
        for (int i = 0; i < 64; i++) begin
            a_en[i] = 0; a_y[i] = '0; a_x[i] = '0; a_base[i] = '0; a_vf[i] = 0; a_hf[i] = 0;
        end
    endtask

    task automatic set_sprite(input int idx, input logic [9:0] y, input logic [9:0] x,
                              input logic [15:0] base, input logic vf, input logic hf);
        a_en[idx] = 1; a_y[idx] = y; a_x[idx] = x; a_base[idx] = base; a_vf[idx] = vf; a_hf[idx] = hf;
    endtask

    // t0 is the cycle in which i_line_start is high.
    task automatic start_line(input logic [9:0] y, output int t0);
        @(posedge clk); #1;
        i_line_y = y;
        i_line_start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        i_line_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int base;
        base = done_cnt;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (done_cnt != base) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (o_valid) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_line_start = 1'b1;
        i_line_y = 10'd7;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b exp 0", o_busy); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b exp 0", o_valid); end
        checks++; if (o_attr_rd !== 1'b0 || o_mask_rd !== 1'b0) begin errors++; $display("FAIL reset_strobes: got %0b/%0b exp 0/0", o_attr_rd, o_mask_rd); end
        checks++; if (o_mask !== 32'h0 || o_addr !== 16'h0 || o_x !== 10'h0 || o_tile_row !== 1'b0 || o_row_flip !== 1'b0) begin
            errors++; $display("FAIL reset_desc: got %h/%h/%0d/%0b/%0b exp zeros", o_mask, o_addr, o_x, o_tile_row, o_row_flip);
        end
        checks++; if (o_line_done !== 1'b0 || o_overflow !== 1'b0 || o_attr_addr !== 6'd0 || o_mask_addr !== 16'h0) begin
            errors++; $display("FAIL reset_misc: got done=%0b ovf=%0b aa=%0d ma=%h exp zeros", o_line_done, o_overflow, o_attr_addr, o_mask_addr);
        end
        i_line_start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_idle_after: got busy=%0b exp 0", o_busy); end
    endtask

    task automatic test_all_miss();
        int t0;
        int base;
        bit ok;
        clear_attrs();
        nd = 0; valid_seen = 0;
        base = done_cnt;
        start_line(10'd5, t0);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL miss_busy: got %0b exp 1", o_busy); end
        wait_done(300, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL miss_done_timeout: got no line_done exp pulse"); end
        checks++; if (done_cyc - t0 != 129) begin errors++; $display("FAIL miss_done_cycle: got T+%0d exp T+129", done_cyc - t0); end
        repeat (4) @(posedge clk);
        #2;
        checks++; if (done_cnt - base != 1) begin errors++; $display("FAIL miss_done_count: got %0d exp 1", done_cnt - base); end
        checks++; if (valid_seen !== 1'b0) begin errors++; $display("FAIL miss_no_valid: got valid seen exp none"); end
        checks++; if (o_overflow !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL miss_end_flags: got ovf=%0b busy=%0b exp 0/0", o_overflow, o_busy); end
    endtask

    task automatic test_single_hit();
        int t0;
        bit ok;
        clear_attrs();
        set_sprite(5, 10'd100, 10'd200, 16'h1000, 1'b0, 1'b0);
        nd = 0;
        i_ready = 1'b1;
        start_line(10'd110, t0);
        wait_done(300, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL hit_done_timeout: got no line_done exp pulse"); end
        checks++; if (nd != 1) begin errors++; $display("FAIL hit_count: got %0d exp 1", nd); end
        checks++; if (d_mask[0] !== 32'hF0F0F0F0) begin errors++; $display("FAIL hit_mask: got %h exp f0f0f0f0", d_mask[0]); end
        checks++; if (d_addr[0] !== 16'h100A) begin errors++; $display("FAIL hit_addr: got %h exp 100a", d_addr[0]); end
        checks++; if (d_x[0] !== 10'd200 || d_tr[0] !== 1'b0 || d_rf[0] !== 1'b0) begin
            errors++; $display("FAIL hit_fields: got x=%0d tr=%0b rf=%0b exp 200/0/0", d_x[0], d_tr[0], d_rf[0]);
        end
    endtask

    task automatic test_flip();
        int t0;
        bit ok;
        clear_attrs();
        set_sprite(5, 10'd100, 10'd200, 16'h1000, 1'b1, 1'b1);
        nd = 0;
        start_line(10'd110, t0);
        wait_done(300, ok);
        checks++; if (ok !== 1'b1 || nd != 1) begin errors++; $display("FAIL flip_count: got done=%0b n=%0d exp 1/1", ok, nd); end
        checks++; if (d_addr[0] !== 16'h1015) begin errors++; $display("FAIL flip_addr: got %h exp 1015", d_addr[0]); end
        checks++; if (d_tr[0] !== 1'b1 || d_rf[0] !== 1'b1) begin errors++; $display("FAIL flip_bits: got tr=%0b rf=%0b exp 1/1", d_tr[0], d_rf[0]); end
        checks++; if (d_mask[0] !== 32'h1015EFEA) begin errors++; $display("FAIL flip_mask: got %h exp 1015efea", d_mask[0]); end
    endtask

    task automatic test_y_wrap();
        int t0;
        bit ok;
        clear_attrs();
        set_sprite(3, 10'd1020, 10'd7, 16'h2000, 1'b0, 1'b0);
        nd = 0;
        start_line(10'd3, t0);
        wait_done(300, ok);
        checks++; if (ok !== 1'b1 || nd != 1) begin errors++; $display("FAIL wrap_count: got done=%0b n=%0d exp 1/1", ok, nd); end
        checks++; if (d_addr[0] !== 16'h2007 || d_mask[0] !== 32'h2007DFF8) begin
            errors++; $display("FAIL wrap_addr: got %h/%h exp 2007/2007dff8", d_addr[0], d_mask[0]);
        end
        checks++; if (d_x[0] !== 10'd7 || d_tr[0] !== 1'b0) begin errors++; $display("FAIL wrap_fields: got x=%0d tr=%0b exp 7/0", d_x[0], d_tr[0]); end
        nd = 0; valid_seen = 0;
        start_line(10'd28, t0);
        wait_done(300, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wrap_miss_timeout: got no line_done exp pulse"); end
        checks++; if (nd != 0 || valid_seen !== 1'b0) begin errors++; $display("FAIL wrap_miss: got n=%0d valid=%0b exp 0/0", nd, valid_seen); end
    endtask

    task automatic test_backpressure();
        int t0;
        bit ok;
        clear_attrs();
        set_sprite(5, 10'd100, 10'd200, 16'h1000, 1'b0, 1'b0);
        nd = 0;
        i_ready = 1'b0;
        start_line(10'd110, t0);
        wait_valid(50, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout: got no o_valid exp 1"); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            checks++;
            if (o_valid !== 1'b1 || o_mask !== 32'hF0F0F0F0 || o_addr !== 16'h100A ||
                o_x !== 10'd200 || o_tile_row !== 1'b0 || o_row_flip !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%0b m=%h a=%h x=%0d tr=%0b rf=%0b exp 1/f0f0f0f0/100a/200/0/0",
                         i, o_valid, o_mask, o_addr, o_x, o_tile_row, o_row_flip);
            end
        end
        i_ready = 1'b1;
        @(posedge clk); #2;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_drop: got %0b exp 0", o_valid); end
        wait_done(300, ok);
        checks++; if (ok !== 1'b1 || nd != 1) begin errors++; $display("FAIL bp_transfers: got done=%0b n=%0d exp 1/1", ok, nd); end
    endtask

    task automatic test_overflow();
        int t0;
        bit ok;
        clear_attrs();
        for (int i = 0; i < 17; i++) set_sprite(i, 10'd50, 10'(i + 1), 16'(i * 256), 1'b0, 1'b0);
        nd = 0;
        i_ready = 1'b1;
        start_line(10'd60, t0);
        wait_done(400, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ovf_done_timeout: got no line_done exp pulse"); end
        checks++; if (nd != 16) begin errors++; $display("FAIL ovf_count: got %0d exp 16", nd); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (d_addr[i] !== 16'(i * 256 + 10) || d_x[i] !== 10'(i + 1)) begin
                errors++; $display("FAIL ovf_order%0d: got a=%h x=%0d exp a=%h x=%0d", i, d_addr[i], d_x[i], 16'(i * 256 + 10), i + 1);
            end
        end
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b exp 1", o_overflow); end
    endtask

    task automatic test_abort();
        int t0;
        int base;
        bit ok;
        clear_attrs();
        set_sprite(5, 10'd100, 10'd200, 16'h1000, 1'b0, 1'b0);
        nd = 0;
        i_ready = 1'b0;
        start_line(10'd110, t0);
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL abort_ovf_clear: got %0b exp 0", o_overflow); end
        wait_valid(50, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL abort_valid_timeout: got no o_valid exp 1"); end
        base = done_cnt;
        start_line(10'd110, t0);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL abort_valid_drop: got %0b exp 0", o_valid); end
        checks++; if (o_attr_rd !== 1'b1 || o_attr_addr !== 6'd0) begin
            errors++; $display("FAIL abort_restart: got rd=%0b addr=%0d exp 1/0", o_attr_rd, o_attr_addr);
        end
        i_ready = 1'b1;
        wait_done(300, ok);
        repeat (4) @(posedge clk);
        #2;
        checks++; if (ok !== 1'b1 || done_cnt - base != 1) begin errors++; $display("FAIL abort_done_count: got %0d exp 1", done_cnt - base); end
        checks++; if (nd != 1 || d_addr[0] !== 16'h100A) begin errors++; $display("FAIL abort_desc: got n=%0d a=%h exp 1/100a", nd, d_addr[0]); end
    endtask

    task automatic test_reset_mid_emit();
        int t0;
        bit ok;
        clear_attrs();
        set_sprite(5, 10'd100, 10'd200, 16'h1000, 1'b0, 1'b0);
        i_ready = 1'b0;
        start_line(10'd110, t0);
        wait_valid(50, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rst_emit_timeout: got no o_valid exp 1"); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_mask !== 32'h0) begin
            errors++; $display("FAIL rst_emit: got v=%0b busy=%0b m=%h exp 0/0/0", o_valid, o_busy, o_mask);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        i_ready = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        clear_attrs();
        test_reset();
        test_all_miss();
        test_single_hit();
        test_flip();
        test_y_wrap();
        test_backpressure();
        test_overflow();
        test_abort();
        test_reset_mid_emit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
